// File: rtl/inference_scheduler_if.sv
// Handshake/bus bundle between the inference scheduler, its request sources,
// the neural_network block and the result display logic.
interface inference_scheduler_if #(
  parameter int NUM_CLASSES = 10,
  parameter int PROB_W      = 16
);
  logic              frame_sync;
  logic              compute;
  logic              canvas_dirty;
  logic              auto_en;
  logic              nn_ready;
  logic [PROB_W-1:0] nn_prob [NUM_CLASSES];
  logic              nn_start;
  logic              busy;
  logic              result_valid;
  logic              result_update;
  logic [3:0]        result_class;
  logic [PROB_W-1:0] result_prob;
  logic              timeout;

  modport master (
    output frame_sync, compute, canvas_dirty, auto_en, nn_ready, nn_prob,
    input  nn_start, busy, result_valid, result_update, result_class,
           result_prob, timeout
  );

  modport slave (
    input  frame_sync, compute, canvas_dirty, auto_en, nn_ready, nn_prob,
    output nn_start, busy, result_valid, result_update, result_class,
           result_prob, timeout
  );
endinterface

// File: rtl/inference_scheduler.sv
// Fires neural_network runs on manual/auto requests, snapshots the class
// probabilities and runs a sequential argmax. Optional WAIT abort: INFER_TIMEOUT_EN.
module inference_scheduler #(
  parameter int NUM_CLASSES = 10,
  parameter int PROB_W      = 16
`ifdef INFER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1_000_000
`endif
) (
  input logic                  clk,
  input logic                  rst,
  inference_scheduler_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_SCAN, S_DONE} state_e;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_e            state_q, state_d;
  logic [1:0]        fs_sync_q, fs_sync_d, cp_sync_q, cp_sync_d;
  logic              fs_prev_q, fs_prev_d, cp_prev_q, cp_prev_d;
  logic              pending_q, pending_d, dirty_q, dirty_d;
  logic              armed_q, armed_d, valid_q, valid_d;
  logic [PROB_W-1:0] snap_q [NUM_CLASSES];
  logic [PROB_W-1:0] snap_d [NUM_CLASSES];
  logic [PROB_W-1:0] best_q, best_d, res_prob_q, res_prob_d;
  logic [3:0]        best_idx_q, best_idx_d, idx_q, idx_d;
  logic [3:0]        res_class_q, res_class_d;

  logic              frame_tick, comp_edge, enter_start, timeout_hit;
  logic [PROB_W-1:0] cand_prob;
  logic [3:0]        cand_idx;

  // Two-flop synchronisers followed by a rising-edge detector.
  always_comb begin
    fs_sync_d  = {fs_sync_q[0], bus.frame_sync};
    cp_sync_d  = {cp_sync_q[0], bus.compute};
    fs_prev_d  = fs_sync_q[1];
    cp_prev_d  = cp_sync_q[1];
    frame_tick = fs_sync_q[1] & ~fs_prev_q;
    comp_edge  = cp_sync_q[1] & ~cp_prev_q;
  end

`ifdef INFER_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_START)     tmo_cnt_d = '0;
    else if (state_q == S_WAIT) tmo_cnt_d = tmo_cnt_q + 32'd1;
  end

  // A response accepted on the expiry cycle wins over the abort.
  assign timeout_hit = (state_q == S_WAIT) && (tmo_cnt_q == 32'(TIMEOUT_CYC - 1))
                       && !(bus.nn_ready && armed_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // One argmax step: strict compare keeps the lowest index on ties.
  always_comb begin
    cand_prob = best_q;
    cand_idx  = best_idx_q;
    if (snap_q[idx_q] > best_q) begin
      cand_prob = snap_q[idx_q];
      cand_idx  = idx_q;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    valid_d     = valid_q;
    snap_d      = snap_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    idx_d       = idx_q;
    res_class_d = res_class_q;
    res_prob_d  = res_prob_q;
    enter_start = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pending_q || (bus.auto_en && frame_tick && dirty_q)) begin
          state_d     = S_START;
          enter_start = 1'b1;
        end
      end
      S_START: begin
        armed_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ready must be seen low first so a stale idle level is not taken as done.
        if (bus.nn_ready && armed_q) begin
          snap_d     = bus.nn_prob;
          best_d     = bus.nn_prob[0];
          best_idx_d = '0;
          idx_d      = 4'd1;
          state_d    = S_SCAN;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end else if (!bus.nn_ready) begin
          armed_d = 1'b1;
        end
      end
      S_SCAN: begin
        best_d     = cand_prob;
        best_idx_d = cand_idx;
        if (idx_q == LAST_IDX) begin
          res_class_d = cand_idx;
          res_prob_d  = cand_prob;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_DONE: begin
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Request set beats the clear on entering START.
    pending_d = comp_edge | (pending_q & ~enter_start);
    dirty_d   = bus.canvas_dirty | timeout_hit | (dirty_q & ~enter_start);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fs_sync_q   <= '0;
      cp_sync_q   <= '0;
      fs_prev_q   <= 1'b0;
      cp_prev_q   <= 1'b0;
      pending_q   <= 1'b0;
      dirty_q     <= 1'b0;
      armed_q     <= 1'b0;
      valid_q     <= 1'b0;
      best_q      <= '0;
      best_idx_q  <= '0;
      idx_q       <= '0;
      res_class_q <= '0;
      res_prob_q  <= '0;
      // NOTE: the snapshot is a small flop array, not RAM, so it is reset
      // like any other register to give a defined post-reset state.
      for (int k = 0; k < NUM_CLASSES; k++) snap_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      fs_sync_q   <= fs_sync_d;
      cp_sync_q   <= cp_sync_d;
      fs_prev_q   <= fs_prev_d;
      cp_prev_q   <= cp_prev_d;
      pending_q   <= pending_d;
      dirty_q     <= dirty_d;
      armed_q     <= armed_d;
      valid_q     <= valid_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      idx_q       <= idx_d;
      res_class_q <= res_class_d;
      res_prob_q  <= res_prob_d;
      snap_q      <= snap_d;
    end
  end

  assign bus.nn_start      = (state_q == S_START);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.result_valid  = valid_q;
  assign bus.result_update = (state_q == S_DONE);
  assign bus.result_class  = res_class_q;
  assign bus.result_prob   = res_prob_q;
  assign bus.timeout       = timeout_hit;

endmodule

// File: tb/tb_inference_scheduler.sv
// Scoreboard bench for inference_scheduler: directed runs push expected
// results; a negedge monitor pops and compares on every result_update.
module tb_inference_scheduler;
  localparam int NC = 10;
  localparam int PW = 16;

  typedef logic [PW-1:0] prob_arr_t [NC];
  typedef struct {
    int cls;
    int prob;
    int cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;
  int   start_count;
  int   timeout_count;
  int   last_start_cyc;
  int   last_update_cyc;
  int   last_timeout_cyc;
  exp_t sb[$];

  inference_scheduler_if #(.NUM_CLASSES(NC), .PROB_W(PW)) bus ();

`ifdef INFER_TIMEOUT_EN
  inference_scheduler #(.NUM_CLASSES(NC), .PROB_W(PW), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`else
  inference_scheduler #(.NUM_CLASSES(NC), .PROB_W(PW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: event counters plus scoreboard comparison on each result update.
  always @(negedge clk) begin
    if (bus.nn_start) begin
      start_count++;
      last_start_cyc = cyc;
    end
    if (bus.timeout) begin
      timeout_count++;
      last_timeout_cyc = cyc;
    end
    if (bus.result_update) begin
      last_update_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_update", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_class", int'(bus.result_class), e.cls);
        check("sb_prob", int'(bus.result_prob), e.prob);
        check("sb_latency", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_probs(input prob_arr_t p);
    for (int i = 0; i < NC; i++) bus.nn_prob[i] = p[i];
  endtask

  task automatic compute_pulse();
    bus.compute = 1'b1;
    tick(3);
    bus.compute = 1'b0;
  endtask

  task automatic frame_tick_pulse();
    bus.frame_sync = 1'b1;
    tick(4);
    bus.frame_sync = 1'b0;
    tick(4);
  endtask

  task automatic wait_start(input int target);
    int t;
    t = 0;
    while (start_count < target && t < 200) begin
      tick(1);
      t++;
    end
    check("start_seen", int'(start_count >= target), 1);
  endtask

  // NN model: hold ready low for lo cycles, then raise it with the result
  // vector; the vector is scrambled right after capture.
  task automatic nn_respond(input prob_arr_t p, input int cls, input int prb, input int lo);
    prob_arr_t junk;
    int t;
    bus.nn_ready = 1'b0;
    if (lo > 0) tick(lo);
    bus.nn_ready = 1'b1;
    set_probs(p);
    sb.push_back('{cls: cls, prob: prb, cyc: cyc + NC});
    tick(1);
    for (int i = 0; i < NC; i++) junk[i] = 16'hFFFF;
    set_probs(junk);
    t = 0;
    while (sb.size() > 0 && t < 100) begin
      tick(1);
      t++;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    prob_arr_t p;
    int s0;
    int t0;
    int t;

    cyc = 0; tests = 0; fails = 0;
    start_count = 0; timeout_count = 0;
    last_start_cyc = 0; last_update_cyc = 0; last_timeout_cyc = 0;
    rst = 1'b1;
    bus.frame_sync = 1'b0; bus.compute = 1'b0; bus.canvas_dirty = 1'b0;
    bus.auto_en = 1'b0; bus.nn_ready = 1'b1;
    for (int i = 0; i < NC; i++) bus.nn_prob[i] = '0;
    tick(3);

    // Reset values
    check("rst_busy", int'(bus.busy), 0);
    check("rst_start", int'(bus.nn_start), 0);
    check("rst_valid", int'(bus.result_valid), 0);
    check("rst_class", int'(bus.result_class), 0);
    rst = 1'b0;
    tick(5);

    // T2: manual run, duplicate max -> lowest index wins
    s0 = start_count;
    compute_pulse();
    wait_start(s0 + 1);
    p = '{16'd5, 16'd9, 16'd3, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    nn_respond(p, 1, 9, 2);
    check("t2_valid", int'(bus.result_valid), 1);
    check("t2_busy_idle", int'(bus.busy), 0);
    check("t2_one_start", start_count, s0 + 1);

    // T5: ready stays high through START and early WAIT with a decoy vector
    s0 = start_count;
    compute_pulse();
    wait_start(s0 + 1);
    for (int i = 0; i < NC; i++) p[i] = '0;
    p[9] = 16'd999;
    set_probs(p);
    tick(3);
    check("t5_still_waiting", int'(bus.busy), 1);
    p = '{16'd100, 16'd200, 16'd300, 16'd50, 16'd300, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7};
    nn_respond(p, 2, 300, 1);

    // T3: auto mode needs both a dirty canvas and a frame tick
    bus.auto_en = 1'b1;
    s0 = start_count;
    repeat (3) frame_tick_pulse();
    tick(5);
    check("t3_no_start_clean", start_count, s0);
    bus.canvas_dirty = 1'b1;
    tick(1);
    bus.canvas_dirty = 1'b0;
    tick(6);
    check("t3_no_start_dirty_only", start_count, s0);
    frame_tick_pulse();
    wait_start(s0 + 1);
    p = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF};
    nn_respond(p, 9, 65535, 2);
    frame_tick_pulse();
    tick(5);
    check("t3_exactly_one_start", start_count, s0 + 1);
    bus.auto_en = 1'b0;

    // T4: compute edge and canvas edit during WAIT queue a second run
    s0 = start_count;
    compute_pulse();
    wait_start(s0 + 1);
    bus.nn_ready = 1'b0;
    bus.compute = 1'b1;
    bus.canvas_dirty = 1'b1;
    tick(1);
    bus.canvas_dirty = 1'b0;
    tick(3);
    bus.compute = 1'b0;
    tick(2);
    p = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6, 16'd5, 16'd3};
    nn_respond(p, 5, 9, 0);
    wait_start(s0 + 2);
    check("t4_restart_gap", last_start_cyc - last_update_cyc, 2);
    check("t4_hold_class", int'(bus.result_class), 5);
    check("t4_hold_prob", int'(bus.result_prob), 9);
    for (int i = 0; i < NC; i++) p[i] = 16'd7;
    nn_respond(p, 0, 7, 2);
    check("t4_two_starts", start_count, s0 + 2);

`ifdef INFER_TIMEOUT_EN
    // T6: ready never returns -> abort at WAIT cycle 100, then auto retry
    s0 = start_count;
    t0 = timeout_count;
    compute_pulse();
    wait_start(s0 + 1);
    bus.nn_ready = 1'b0;
    t = 0;
    while (timeout_count == t0 && t < 300) begin
      tick(1);
      t++;
    end
    check("t6_timeout_seen", timeout_count, t0 + 1);
    check("t6_timeout_gap", last_timeout_cyc - last_start_cyc, 100);
    check("t6_class_kept", int'(bus.result_class), 0);
    check("t6_prob_kept", int'(bus.result_prob), 7);
    tick(1);
    check("t6_idle", int'(bus.busy), 0);
    bus.nn_ready = 1'b1;
    bus.auto_en = 1'b1;
    frame_tick_pulse();
    wait_start(s0 + 2);
    p = '{16'd8, 16'd8, 16'd8, 16'd8, 16'd8, 16'd8, 16'd8, 16'd8, 16'd9, 16'd8};
    nn_respond(p, 8, 9, 2);
    bus.auto_en = 1'b0;
    check("t6_single_timeout", timeout_count, t0 + 1);
`else
    t0 = 0;
    t = 0;
    check("no_timeout_pulses", timeout_count, t0 + t);
`endif

    // T1: reset in the middle of WAIT
    s0 = start_count;
    compute_pulse();
    wait_start(s0 + 1);
    bus.nn_ready = 1'b0;
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    check("t1_busy", int'(bus.busy), 0);
    check("t1_start", int'(bus.nn_start), 0);
    check("t1_valid", int'(bus.result_valid), 0);
    check("t1_update", int'(bus.result_update), 0);
    check("t1_class", int'(bus.result_class), 0);
    check("t1_prob", int'(bus.result_prob), 0);
    check("t1_timeout", int'(bus.timeout), 0);
    tick(2);
    rst = 1'b0;
    bus.nn_ready = 1'b1;
    tick(20);
    check("t1_no_start_after", start_count, s0 + 1);
    check("t1_idle_after", int'(bus.busy), 0);
    check("sb_empty_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
